// File: rtl/open_list_pq.sv
// open_list_pq: A* open-list priority queue.
// Sorted shift-register array, head at entry[0]. Key = {f, h}, ascending.
// Equal keys keep insertion order. Define OPEN_LIST_DEDUP_EN to collapse
// inserts whose (row, col) already sits in the queue.
module open_list_pq #(
  parameter int DEPTH = 32,
  parameter int F_W   = 8,
  parameter int H_W   = 7,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             insert_en,
  input  logic [3:0]       insert_row,
  input  logic [3:0]       insert_col,
  input  logic [F_W-1:0]   insert_f,
  input  logic [H_W-1:0]   insert_h,
  input  logic             pop_req,
  output logic             pop_valid,
  output logic [3:0]       pop_row,
  output logic [3:0]       pop_col,
  output logic [F_W-1:0]   pop_f,
  output logic [H_W-1:0]   pop_h,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int K_W = F_W + H_W;

  typedef struct packed {
    logic           v;
    logic [3:0]     row;
    logic [3:0]     col;
    logic [F_W-1:0] f;
    logic [H_W-1:0] h;
  } ent_t;

  function automatic logic [K_W-1:0] key(input ent_t e);
    return {e.f, e.h};
  endfunction

  ent_t [DEPTH-1:0] r_ent;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic             r_pop_valid;
  logic [3:0]       r_pop_row;
  logic [3:0]       r_pop_col;
  logic [F_W-1:0]   r_pop_f;
  logic [H_W-1:0]   r_pop_h;

  ent_t [DEPTH:0]   w_e;      // current array plus an always-empty slot on top
  ent_t [DEPTH:0]   w_a;      // array after the pop (if any)
  ent_t [DEPTH-1:0] w_b;      // after duplicate removal (if any)
  ent_t [DEPTH-1:0] w_c;      // after insertion: next state
  ent_t             w_new;
  logic             w_pop;
  logic             w_rem;
  logic             w_dup_drop;
  logic [CNT_W-1:0] w_midx;
  logic [CNT_W-1:0] w_cnt_a;
  logic [CNT_W-1:0] w_cnt_b;
  logic [CNT_W-1:0] w_pos;
  logic             w_found;
  logic             w_ins;
  logic             w_ovf;

  // Post-pop view: the head leaves and everything slides down one place.
  always_comb begin
    w_pop = pop_req && (r_count != '0);
    w_new.v   = 1'b1;
    w_new.row = insert_row;
    w_new.col = insert_col;
    w_new.f   = insert_f;
    w_new.h   = insert_h;
    w_e[DEPTH-1:0] = r_ent;
    w_e[DEPTH]     = '0;
    w_a[DEPTH]     = '0;
    for (int i = 0; i < DEPTH; i++)
      w_a[i] = w_pop ? w_e[i+1] : w_e[i];
  end

`ifdef OPEN_LIST_DEDUP_EN
  // Look for the same cell in the post-pop array; a better key replaces it.
  always_comb begin
    logic           m;
    logic [K_W-1:0] mkey;
    m      = 1'b0;
    mkey   = '0;
    w_midx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!m && w_a[i].v && w_a[i].row == insert_row && w_a[i].col == insert_col) begin
        m      = 1'b1;
        mkey   = key(w_a[i]);
        w_midx = CNT_W'(i);
      end
    end
    w_dup_drop = insert_en && m && (key(w_new) >= mkey);
    w_rem      = insert_en && m && (key(w_new) <  mkey);
  end
`else
  // Duplicates are stored as independent entries.
  always_comb begin
    w_midx     = '0;
    w_dup_drop = 1'b0;
    w_rem      = 1'b0;
  end
`endif

  // Remove the superseded duplicate, settle counts, find the insert slot.
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      w_b[i] = (w_rem && CNT_W'(i) >= w_midx) ? w_a[i+1] : w_a[i];
    w_cnt_a = r_count - CNT_W'(w_pop);
    w_cnt_b = w_cnt_a - CNT_W'(w_rem);
    w_ins   = insert_en && !w_dup_drop && (w_cnt_b < CNT_W'(DEPTH));
    w_ovf   = insert_en && !w_dup_drop && (w_cnt_b == CNT_W'(DEPTH));
    // strict > keeps equal keys in arrival order
    w_pos   = CNT_W'(DEPTH);
    w_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_found && (!w_b[i].v || key(w_b[i]) > key(w_new))) begin
        w_found = 1'b1;
        w_pos   = CNT_W'(i);
      end
    end
  end

  // Open a gap at the insert slot and drop the new entry into it.
  always_comb begin
    w_c[0] = (w_ins && w_pos == '0) ? w_new : w_b[0];
    for (int i = 1; i < DEPTH; i++) begin
      if (w_ins && CNT_W'(i) == w_pos)     w_c[i] = w_new;
      else if (w_ins && CNT_W'(i) > w_pos) w_c[i] = w_b[i-1];
      else                                 w_c[i] = w_b[i];
    end
  end

  // State update: clear beats insert/pop; pop fields hold when not popping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ent       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_pop_valid <= 1'b0;
      r_pop_row   <= '0;
      r_pop_col   <= '0;
      r_pop_f     <= '0;
      r_pop_h     <= '0;
    end else if (clear) begin
      r_ent       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_pop_valid <= 1'b0;
    end else begin
      r_ent       <= w_c;
      r_count     <= w_cnt_b + CNT_W'(w_ins);
      if (w_ovf) r_ovf <= 1'b1;
      r_pop_valid <= w_pop;
      if (w_pop) begin
        r_pop_row <= r_ent[0].row;
        r_pop_col <= r_ent[0].col;
        r_pop_f   <= r_ent[0].f;
        r_pop_h   <= r_ent[0].h;
      end
    end
  end

  assign pop_valid = r_pop_valid;
  assign pop_row   = r_pop_row;
  assign pop_col   = r_pop_col;
  assign pop_f     = r_pop_f;
  assign pop_h     = r_pop_h;
  assign count     = r_count;
  assign empty     = (r_count == '0);
  assign full      = (r_count == CNT_W'(DEPTH));
  assign overflow  = r_ovf;

endmodule
